// File: rtl/rr_bus_arbiter_if.sv
// Bundle of request, data and grant signals shared between the requesters and
// the round-robin bus arbiter.
interface rr_bus_arbiter_if;
    logic [3:0]  req;
    logic [31:0] data_in0;
    logic [31:0] data_in1;
    logic [31:0] data_in2;
    logic [31:0] data_in3;
    logic [3:0]  grant;
    logic [31:0] data_out;
    logic        valid_out;
    logic        expired;

    // Requester side: raises req[i] and presents its word; reads the grant back.
    modport master (
        output req,
        output data_in0,
        output data_in1,
        output data_in2,
        output data_in3,
        input  grant,
        input  data_out,
        input  valid_out,
        input  expired
    );

    // Arbiter side.
    modport slave (
        input  req,
        input  data_in0,
        input  data_in1,
        input  data_in2,
        input  data_in3,
        output grant,
        output data_out,
        output valid_out,
        output expired
    );
endinterface

// File: rtl/rr_bus_arbiter.sv
// Four-requester round-robin arbiter for a shared 32-bit bus with a hold limit;
// every ownership ends in at least one IDLE cycle before the next grant.
module rr_bus_arbiter #(
    parameter int unsigned MAX_HOLD = 16  // legal range 2..255
) (
    input  logic             clk,
    input  logic             rst,
    rr_bus_arbiter_if.slave  bus,
    output logic             dbg_state,
    output logic [1:0]       dbg_owner,
    output logic [1:0]       dbg_ptr,
    output logic [7:0]       dbg_hold_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       expired_q, expired_d;

    logic [1:0] winner;
    logic       found;
    logic [1:0] scan_idx;

    // Rotating-priority scan starting at ptr; only consulted while IDLE.
    always_comb begin
        winner   = ptr_q;
        found    = 1'b0;
        scan_idx = ptr_q;
        for (int k = 0; k < 4; k++) begin
            scan_idx = ptr_q + 2'(k);
            if (!found && bus.req[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        expired_d  = 1'b0;
        case (state_q)
            IDLE: begin
                hold_cnt_d = 8'd0;
                if (found) begin
                    state_d = BUSY;
                    owner_d = winner;
                end
            end
            BUSY: begin
                // Release is tested first so it wins over a coincident expiry.
                if (!bus.req[owner_q]) begin
                    state_d    = IDLE;
                    ptr_d      = owner_q + 2'd1;
                    hold_cnt_d = 8'd0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = IDLE;
                    ptr_d      = owner_q + 2'd1;
                    hold_cnt_d = 8'd0;
                    expired_d  = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d    = IDLE;
                hold_cnt_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= 2'd0;
            ptr_q      <= 2'd0;
            hold_cnt_q <= 8'd0;
            expired_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            expired_q  <= expired_d;
        end
    end

    // Grant comes only from registered state; data path follows the owner live.
    always_comb begin
        bus.grant     = 4'b0000;
        bus.data_out  = 32'h0;
        bus.valid_out = 1'b0;
        if (state_q == BUSY) begin
            bus.grant     = 4'b0001 << owner_q;
            bus.valid_out = bus.req[owner_q];
            case (owner_q)
                2'd0:    bus.data_out = bus.data_in0;
                2'd1:    bus.data_out = bus.data_in1;
                2'd2:    bus.data_out = bus.data_in2;
                default: bus.data_out = bus.data_in3;
            endcase
        end
    end

    assign bus.expired   = expired_q;
    assign dbg_state     = state_q;
    assign dbg_owner     = owner_q;
    assign dbg_ptr       = ptr_q;
    assign dbg_hold_cnt  = hold_cnt_q;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed bench for rr_bus_arbiter with MAX_HOLD=4: a vector table of
// per-edge expectations plus hand sequences for intra-cycle behaviour.
module tb_rr_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        dbg_state;
    logic [1:0]  dbg_owner;
    logic [1:0]  dbg_ptr;
    logic [7:0]  dbg_hold_cnt;
    logic [31:0] data_w [4];
    int          checks;
    int          errors;
    logic        mon_en;

    rr_bus_arbiter_if bus ();

    rr_bus_arbiter #(.MAX_HOLD(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .dbg_state    (dbg_state),
        .dbg_owner    (dbg_owner),
        .dbg_ptr      (dbg_ptr),
        .dbg_hold_cnt (dbg_hold_cnt)
    );

    assign bus.data_in0 = data_w[0];
    assign bus.data_in1 = data_w[1];
    assign bus.data_in2 = data_w[2];
    assign bus.data_in3 = data_w[3];

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs of one cycle and the outputs expected just after the edge that samples them.
    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] exp_grant;
        logic       exp_valid;
        logic       exp_expired;
        logic [1:0] exp_ptr;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic r, input logic [3:0] q, input logic [3:0] g,
                           input logic v, input logic e, input logic [1:0] p);
        vec_t tmp;
        tmp.rst = r; tmp.req = q; tmp.exp_grant = g;
        tmp.exp_valid = v; tmp.exp_expired = e; tmp.exp_ptr = p;
        vecs.push_back(tmp);
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_data(input logic [3:0] g);
        case (g)
            4'b0001: return data_w[0];
            4'b0010: return data_w[1];
            4'b0100: return data_w[2];
            4'b1000: return data_w[3];
            default: return 32'h0;
        endcase
    endfunction

    // ---------------- every-cycle invariants ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (!$onehot0(bus.grant)) begin
                errors++;
                $display("FAIL inv_onehot: grant %b", bus.grant);
            end
            checks++;
            if (bus.valid_out && bus.grant == 4'b0000) begin
                errors++;
                $display("FAIL inv_valid_grant: valid_out 1 with grant %b", bus.grant);
            end
            checks++;
            if (bus.grant == 4'b0000 && bus.data_out !== 32'h0) begin
                errors++;
                $display("FAIL inv_data_zero: data_out %h expected 00000000", bus.data_out);
            end
            checks++;
            if (dbg_state !== (bus.grant != 4'b0000)) begin
                errors++;
                $display("FAIL inv_state_grant: state %b grant %b", dbg_state, bus.grant);
            end
            checks++;
            if (bus.grant != 4'b0000 && bus.grant !== (4'b0001 << dbg_owner)) begin
                errors++;
                $display("FAIL inv_owner_grant: owner %0d grant %b", dbg_owner, bus.grant);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        checks = 0;
        errors = 0;
        mon_en = 1'b0;
        data_w[0] = 32'h1111_0001;
        data_w[1] = 32'h2222_0002;
        data_w[2] = 32'hDEAD_BEEF;
        data_w[3] = 32'h4444_0004;
        rst = 1'b1;
        bus.req = 4'b0000;

        // Reset ignores req; basic grant to requester 2 and release (ptr -> 3).
        add_vec(1, 4'b1111, 4'b0000, 0, 0, 2'd0);
        add_vec(1, 4'b0000, 4'b0000, 0, 0, 2'd0);
        add_vec(0, 4'b0100, 4'b0100, 1, 0, 2'd0);
        add_vec(0, 4'b0000, 4'b0000, 0, 0, 2'd3);
        // Rotation from ptr=0, each owner keeps the bus 2 cycles, one IDLE between.
        add_vec(1, 4'b0000, 4'b0000, 0, 0, 2'd0);
        add_vec(0, 4'b1111, 4'b0001, 1, 0, 2'd0);
        add_vec(0, 4'b1111, 4'b0001, 1, 0, 2'd0);
        add_vec(0, 4'b1110, 4'b0000, 0, 0, 2'd1);
        add_vec(0, 4'b1111, 4'b0010, 1, 0, 2'd1);
        add_vec(0, 4'b1111, 4'b0010, 1, 0, 2'd1);
        add_vec(0, 4'b1101, 4'b0000, 0, 0, 2'd2);
        add_vec(0, 4'b1111, 4'b0100, 1, 0, 2'd2);
        add_vec(0, 4'b1111, 4'b0100, 1, 0, 2'd2);
        add_vec(0, 4'b1011, 4'b0000, 0, 0, 2'd3);
        add_vec(0, 4'b1111, 4'b1000, 1, 0, 2'd3);
        add_vec(0, 4'b1111, 4'b1000, 1, 0, 2'd3);
        add_vec(0, 4'b0111, 4'b0000, 0, 0, 2'd0);
        add_vec(0, 4'b1111, 4'b0001, 1, 0, 2'd0);
        add_vec(0, 4'b1110, 4'b0000, 0, 0, 2'd1);
        // Hold limit: requester 0 owns 4 cycles, expires, then requester 1.
        add_vec(1, 4'b0000, 4'b0000, 0, 0, 2'd0);
        add_vec(0, 4'b0011, 4'b0001, 1, 0, 2'd0);
        add_vec(0, 4'b0011, 4'b0001, 1, 0, 2'd0);
        add_vec(0, 4'b0011, 4'b0001, 1, 0, 2'd0);
        add_vec(0, 4'b0011, 4'b0001, 1, 0, 2'd0);
        add_vec(0, 4'b0011, 4'b0000, 0, 1, 2'd1);
        add_vec(0, 4'b0011, 4'b0010, 1, 0, 2'd1);
        // Non-owner bits wiggle; then release coincides with hold_cnt==3.
        add_vec(0, 4'b0010, 4'b0010, 1, 0, 2'd1);
        add_vec(0, 4'b1111, 4'b0010, 1, 0, 2'd1);
        add_vec(0, 4'b0110, 4'b0010, 1, 0, 2'd1);
        add_vec(0, 4'b0001, 4'b0000, 0, 0, 2'd2);
        add_vec(0, 4'b0000, 4'b0000, 0, 0, 2'd2);
        // Reach ptr=3, requester 3 owns, reset mid-ownership, then 1001 -> requester 0.
        add_vec(0, 4'b0100, 4'b0100, 1, 0, 2'd2);
        add_vec(0, 4'b0000, 4'b0000, 0, 0, 2'd3);
        add_vec(0, 4'b1000, 4'b1000, 1, 0, 2'd3);
        add_vec(0, 4'b1000, 4'b1000, 1, 0, 2'd3);
        add_vec(1, 4'b1000, 4'b0000, 0, 0, 2'd0);
        add_vec(0, 4'b1001, 4'b0001, 1, 0, 2'd0);
        add_vec(0, 4'b0000, 4'b0000, 0, 0, 2'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst;
            bus.req = vecs[i].req;
            @(posedge clk);
            #1;
            mon_en = 1'b1;
            check_val($sformatf("v%0d grant", i), 32'(bus.grant), 32'(vecs[i].exp_grant));
            check_val($sformatf("v%0d valid_out", i), 32'(bus.valid_out), 32'(vecs[i].exp_valid));
            check_val($sformatf("v%0d expired", i), 32'(bus.expired), 32'(vecs[i].exp_expired));
            check_val($sformatf("v%0d data_out", i), bus.data_out, exp_data(vecs[i].exp_grant));
            check_val($sformatf("v%0d ptr", i), 32'(dbg_ptr), 32'(vecs[i].exp_ptr));
        end

        // Grant must wait for the edge; data follows the owner's word live;
        // valid_out drops as soon as the owner lowers req.
        rst = 1'b0;
        bus.req = 4'b0010;
        #2;
        check_val("no_comb_grant", 32'(bus.grant), 32'h0);
        @(posedge clk);
        #1;
        check_val("seq_grant1", 32'(bus.grant), 32'h2);
        data_w[1] = 32'hCAFE_F00D;
        #1;
        check_val("seq_data_live", bus.data_out, 32'hCAFE_F00D);
        bus.req = 4'b0000;
        #1;
        check_val("seq_valid_drop", 32'(bus.valid_out), 32'h0);
        check_val("seq_grant_held", 32'(bus.grant), 32'h2);
        check_val("seq_data_held", bus.data_out, 32'hCAFE_F00D);
        @(posedge clk);
        #1;
        check_val("seq_release_grant", 32'(bus.grant), 32'h0);
        check_val("seq_release_ptr", 32'(dbg_ptr), 32'h2);

        // Reset arriving on the would-be expiry edge wins and suppresses expired.
        bus.req = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
        end
        check_val("rst_exp_hold", 32'(dbg_hold_cnt), 32'h3);
        check_val("rst_exp_grant_before", 32'(bus.grant), 32'h4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_val("rst_exp_grant", 32'(bus.grant), 32'h0);
        check_val("rst_exp_expired", 32'(bus.expired), 32'h0);
        check_val("rst_exp_ptr", 32'(dbg_ptr), 32'h0);
        rst = 1'b0;
        bus.req = 4'b0000;
        @(posedge clk);
        #1;
        check_val("rst_exp_idle_expired", 32'(bus.expired), 32'h0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
